// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, op classes, the raw instruction
// view and the micro-op handed to execute.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_OP_IMM,
    OP_OP,
    OP_MISC_MEM,
    OP_SYSTEM,
    OP_ILLEGAL
  } OpClass;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } RTypeFields;

  typedef union packed {
    logic [31:0] inst32;
    RTypeFields  r;
  } Instruction;

  typedef struct packed {
    logic [31:0] pc;
    OpClass      op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } DecodedInst;

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// Purely combinational RV32I decoder: raw instruction + pc -> DecodedInst.
module inst_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output DecodedInst  uop
);

  Instruction  ins;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        keep_rs1, keep_rs2, keep_rd;

  assign ins   = inst;
  assign f3    = ins.r.funct3;
  assign f7    = ins.r.funct7;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    uop        = '0;
    keep_rs1   = 1'b1;
    keep_rs2   = 1'b0;
    keep_rd    = 1'b1;
    uop.pc     = pc;
    uop.funct3 = f3;
    uop.op     = OP_ILLEGAL;
    case (ins.r.opcode)
      OPC_LUI:      begin uop.op = OP_LUI;   uop.imm = imm_u; keep_rs1 = 1'b0; end
      OPC_AUIPC:    begin uop.op = OP_AUIPC; uop.imm = imm_u; keep_rs1 = 1'b0; end
      OPC_JAL:      begin uop.op = OP_JAL;   uop.imm = imm_j; keep_rs1 = 1'b0; end
      OPC_JALR: begin
        uop.op      = OP_JALR;
        uop.imm     = imm_i;
        uop.illegal = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        uop.op      = OP_BRANCH;
        uop.imm     = imm_b;
        keep_rs2    = 1'b1;
        keep_rd     = 1'b0;
        uop.illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        uop.op      = OP_LOAD;
        uop.imm     = imm_i;
        uop.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        uop.op      = OP_STORE;
        uop.imm     = imm_s;
        keep_rs2    = 1'b1;
        keep_rd     = 1'b0;
        uop.illegal = (f3 > 3'd2);
      end
      OPC_OP_IMM: begin
        uop.op      = OP_OP_IMM;
        uop.imm     = imm_i;
        uop.alt     = (f3 == 3'd5) ? inst[30] : 1'b0;
        uop.illegal = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                      ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OPC_OP: begin
        uop.op      = OP_OP;
        keep_rs2    = 1'b1;
        uop.alt     = inst[30];
        uop.illegal = !((f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OPC_MISC_MEM: begin uop.op = OP_MISC_MEM; keep_rd = 1'b0; end
      OPC_SYSTEM:   begin uop.op = OP_SYSTEM;   uop.imm = imm_i; end
      default: begin
        uop.illegal = 1'b1;
        keep_rs1    = 1'b0;
        keep_rd     = 1'b0;
      end
    endcase
    // Unused register fields are zeroed so hazard logic downstream never sees junk.
    uop.rs1       = keep_rs1 ? ins.r.rs1 : 5'd0;
    uop.rs2       = keep_rs2 ? ins.r.rs2 : 5'd0;
    uop.rd        = keep_rd  ? ins.r.rd  : 5'd0;
    uop.uses_rs1  = keep_rs1;
    uop.uses_rs2  = keep_rs2;
    uop.writes_rd = keep_rd && (ins.r.rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: buffers fetched instructions in a circular queue (with an
// empty-queue bypass) and issues registered micro-ops over valid/ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        queue_full,
  output logic        overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output DecodedInst  out_uop
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      q_inst [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic        slot_free, deq, bypass, want_enq, enq, drop;
  logic [31:0] src_inst, src_pc;
  DecodedInst  dec_uop;

  assign queue_full = (count == CNT_W'(QUEUE_DEPTH));
  assign slot_free  = !out_valid || out_ready;
  assign deq        = slot_free && (count != '0);
  assign bypass     = slot_free && (count == '0) && in_valid;
  assign want_enq   = in_valid && !bypass;
  // A full queue can still accept when its head leaves in the same cycle.
  assign enq        = want_enq && (!queue_full || deq);
  assign drop       = want_enq && queue_full && !deq;
  assign src_inst   = (count != '0) ? q_inst[head] : in_inst;
  assign src_pc     = (count != '0) ? q_pc[head]   : in_pc;

  inst_decoder u_decoder (
    .inst (src_inst),
    .pc   (src_pc),
    .uop  (dec_uop)
  );

  always_ff @(posedge clk) begin
    if (rst_n && !flush && enq) begin
      q_inst[tail] <= in_inst;
      q_pc[tail]   <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_uop   <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
      if (slot_free) begin
        out_valid <= deq || bypass;
        if (deq || bypass) out_uop <= dec_uop;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed and model-checked random bench for decode_stage.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        queue_full, overflow, out_valid;
  DecodedInst  uop;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic        mv, mov;
  logic [31:0] mout, npc;

  decode_stage #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .queue_full (queue_full),
    .overflow   (overflow),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_uop    (uop)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rst_valid", 96'(out_valid), 96'(0));
    checkOutput("rst_uop", 96'(uop), 96'(0));
    checkOutput("rst_ovf", 96'(overflow), 96'(0));
    checkOutput("rst_full", 96'(queue_full), 96'(0));

    applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    tick();
    checkOutput("addi_valid", 96'(out_valid), 96'(1));
    checkOutput("addi_op", 96'(uop.op), 96'(OP_OP_IMM));
    checkOutput("addi_rd", 96'(uop.rd), 96'(1));
    checkOutput("addi_rs1", 96'(uop.rs1), 96'(0));
    checkOutput("addi_imm", 96'(uop.imm), 96'(5));
    checkOutput("addi_wrd", 96'(uop.writes_rd), 96'(1));
    checkOutput("addi_ill", 96'(uop.illegal), 96'(0));
    checkOutput("addi_pc", 96'(uop.pc), 96'(32'h100));

    applyStimulus(1'b1, 32'hFE208EE3, 32'h104, 1'b1, 1'b0);
    tick();
    checkOutput("beq_valid", 96'(out_valid), 96'(1));
    checkOutput("beq_op", 96'(uop.op), 96'(OP_BRANCH));
    checkOutput("beq_rs1", 96'(uop.rs1), 96'(1));
    checkOutput("beq_rs2", 96'(uop.rs2), 96'(2));
    checkOutput("beq_rd", 96'(uop.rd), 96'(0));
    checkOutput("beq_imm", 96'(uop.imm), 96'(32'hFFFFFFFC));
    checkOutput("beq_wrd", 96'(uop.writes_rd), 96'(0));

    applyStimulus(1'b1, 32'h123452B7, 32'h108, 1'b1, 1'b0);
    tick();
    checkOutput("lui_op", 96'(uop.op), 96'(OP_LUI));
    checkOutput("lui_rd", 96'(uop.rd), 96'(5));
    checkOutput("lui_imm", 96'(uop.imm), 96'(32'h12345000));
    checkOutput("lui_rs1", 96'(uop.rs1), 96'(0));

    applyStimulus(1'b1, 32'h00000000, 32'h10C, 1'b1, 1'b0);
    tick();
    checkOutput("zero_valid", 96'(out_valid), 96'(1));
    checkOutput("zero_ill", 96'(uop.illegal), 96'(1));
    checkOutput("zero_op", 96'(uop.op), 96'(OP_ILLEGAL));

    applyStimulus(1'b1, 32'h0200D033, 32'h110, 1'b1, 1'b0);
    tick();
    checkOutput("f7_valid", 96'(out_valid), 96'(1));
    checkOutput("f7_ill", 96'(uop.illegal), 96'(1));
    checkOutput("f7_op", 96'(uop.op), 96'(OP_OP));

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("idle_valid", 96'(out_valid), 96'(0));

    // Stall execute and push six instructions: one held, four queued, one dropped.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h00500093, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      tick();
      if (i == 4) checkOutput("fill_full", 96'(queue_full), 96'(1));
      if (i == 4) checkOutput("fill_noovf", 96'(overflow), 96'(0));
    end
    checkOutput("ovf_set", 96'(overflow), 96'(1));
    checkOutput("ovf_full", 96'(queue_full), 96'(1));
    checkOutput("ovf_hold_pc", 96'(uop.pc), 96'(32'h200));
    checkOutput("ovf_hold_v", 96'(out_valid), 96'(1));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      checkOutput("drain_valid", 96'(out_valid), 96'(1));
      checkOutput("drain_pc", 96'(uop.pc), 96'(32'h200 + 32'(4 * i)));
    end
    checkOutput("drain_notfull", 96'(queue_full), 96'(0));
    tick();
    checkOutput("drain_end", 96'(out_valid), 96'(0));

    // Three queued plus one held, then flush with a wrong-path instruction.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h00500093, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("preflush_v", 96'(out_valid), 96'(1));
    applyStimulus(1'b1, 32'h00500093, 32'h3F0, 1'b0, 1'b1);
    tick();
    checkOutput("flush_valid", 96'(out_valid), 96'(0));
    checkOutput("flush_full", 96'(queue_full), 96'(0));
    checkOutput("flush_keepovf", 96'(overflow), 96'(1));
    applyStimulus(1'b1, 32'h00500093, 32'h400, 1'b1, 1'b0);
    tick();
    checkOutput("postflush_v", 96'(out_valid), 96'(1));
    checkOutput("postflush_pc", 96'(uop.pc), 96'(32'h400));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("postflush_empty", 96'(out_valid), 96'(0));

    // Random traffic against a reference queue model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mq.delete();
    mv   = 1'b0;
    mov  = 1'b0;
    mout = 32'h0;
    npc  = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      logic v, rdy, fl, free, byp;
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 29) == 0);
      byp  = 1'b0;
      applyStimulus(v, 32'h00500093, npc, rdy, fl);
      if (fl) begin
        mq.delete();
        mv = 1'b0;
      end else begin
        free = !mv || rdy;
        if (free) begin
          if (mq.size() > 0) begin
            mout = mq.pop_front();
            mv   = 1'b1;
          end else if (v) begin
            mout = npc;
            mv   = 1'b1;
            byp  = 1'b1;
          end else begin
            mv = 1'b0;
          end
        end
        if (v && !byp) begin
          if (mq.size() < DEPTH) mq.push_back(npc);
          else mov = 1'b1;
        end
      end
      npc = npc + 32'd4;
      tick();
      checkOutput("rnd_valid", 96'(out_valid), 96'(mv));
      if (mv) checkOutput("rnd_pc", 96'(uop.pc), 96'(mout));
      checkOutput("rnd_full", 96'(queue_full), 96'(mq.size() == DEPTH));
      checkOutput("rnd_ovf", 96'(overflow), 96'(mov));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage; sits directly downstream of the fetch stage.
- Accepts fetched instructions (inst_valid/inst/inst_pc), which arrive without backpressure, and buffers them in a small instruction queue.
- Decodes the queue head into a registered micro-op and hands it to the execute stage over a valid/ready handshake.
- Discards all buffered and in-flight state on a fetch misprediction flush (pred_miss).

Parameters:
- QUEUE_DEPTH, 4: instruction queue entries. Power of two, >= 2. Matches fetch's outstanding-PC history depth.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  driven by fetch pred_miss; kills all buffered and incoming instructions
- in_valid  input  1  fetch inst_valid
- in_inst  input  32  fetch inst.inst32
- in_pc  input  32  fetch inst_pc
- queue_full  output  1  queue holds QUEUE_DEPTH entries (combinational from count)
- overflow  output  1  sticky: an instruction was dropped because the queue was full
- out_valid  output  1  decoded micro-op valid
- out_ready  input  1  execute accepts the micro-op
- out_uop  output  DecodedInst  packed decoded micro-op (see Decomposition)

Behaviour:
- Reset (rst_n=0 at posedge):
  - queue empty: head = tail = count = 0
  - out_valid=0, out_uop all-zero, overflow=0
  - queue_full=0 after the edge
- Output register:
  - Loaded when out_valid=0 or out_ready=1 (slot free).
  - Source is the queue head if count>0. Otherwise, bypass: in_valid with count=0 loads the input directly, giving 1-cycle latency from fetch to out_valid.
  - With nothing to load, out_valid goes to 0.
  - out_uop holds stable while out_valid=1 and out_ready=0.
- Enqueue:
  - An in_valid not consumed by bypass is written at tail.
  - If count==QUEUE_DEPTH and no dequeue occurs that cycle, the instruction is dropped and overflow is set (it is a fetch-throttling bug indicator).
  - Simultaneous enqueue and dequeue on a full queue is legal; count stays the same.
- Ordering:
  - Strict FIFO; bypass only when the queue is empty.
  - Head and tail pointers wrap modulo QUEUE_DEPTH.
  - count width is clog2(QUEUE_DEPTH)+1.
- Flush (flush=1 at posedge):
  - count, head and tail cleared; out_valid=0.
  - in_valid in the same cycle is discarded (wrong-path).
  - Takes priority over enqueue, dequeue and out_ready.
  - overflow is not cleared by flush.
- Decode (combinational on the selected source, registered into out_uop):
  - opcode = inst[6:0]. inst[1:0] != 2'b11 -> illegal.
  - Classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, MISC_MEM 0001111, SYSTEM 1110011. Anything else -> OP_ILLEGAL, illegal=1.
  - Illegal funct checks:
    - JALR funct3 != 0
    - BRANCH funct3 in {2,3}
    - LOAD funct3 in {3,6,7}
    - STORE funct3 > 2
    - OP funct7 not in {0x00,0x20}, or 0x20 with funct3 not in {0,5}
    - OP_IMM shift: funct3=1 needs funct7=0x00; funct3=5 needs funct7 in {0x00,0x20}
  - Immediates, sign-extended to 32 bits:
    - I: JALR, LOAD, OP_IMM, SYSTEM
    - S: STORE
    - B: BRANCH, bit0=0
    - U: LUI, AUIPC, low 12 bits zero
    - J: JAL, bit0=0
    - Others: imm=0.
  - Register fields forced to 0 when unused:
    - rs1: LUI, AUIPC, JAL
    - rs2: everything except BRANCH, STORE, OP
    - rd: BRANCH, STORE, MISC_MEM
  - Flags: uses_rs1, uses_rs2, writes_rd. writes_rd=0 when rd==0.
  - pc copied unmodified. funct3 = inst[14:12]; alt = inst[30] for OP and for OP_IMM funct3=5, else 0.
  - An illegal instruction still issues with out_valid=1 and illegal=1; execute raises the trap.

Decomposition:
- Shared core package holds:
  - opcode localparams
  - OpClass enum (OP_LUI … OP_ILLEGAL)
  - DecodedInst packed struct: pc[31:0], op, rd, rs1, rs2, funct3, alt, imm[31:0], uses_rs1, uses_rs2, writes_rd, illegal
- The existing Instruction union is reused.
- One sub-module: inst_decoder, purely combinational (inst, pc -> DecodedInst).
- The queue is a local circular buffer. The existing FIFO is not reused, because it lacks a bypass path and a count-aware full.

Test Plan:
- Reset then in_valid with 0x00500093 @pc 0x100, out_ready=1 -> next cycle out_valid=1, op=OP_IMM, rd=1, rs1=0, imm=5, writes_rd=1, illegal=0.
- 0xFE208EE3 (BEQ x1,x2,-4) -> op=BRANCH, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, writes_rd=0. 0x123452B7 -> op=LUI, rd=5, imm=0x12345000, rs1=0.
- in_inst 0x00000000 and 0x0200D033 (funct7=1) -> out_valid=1, illegal=1.
- out_ready=0, QUEUE_DEPTH=4, 6 consecutive in_valid:
  - 1st held in output register, next 4 fill the queue, queue_full=1, 6th dropped, overflow=1.
  - Then out_ready=1 -> 5 micro-ops emerge in PC order, one per cycle.
- Queue holds 3 entries, out_valid=1, and flush=1 with in_valid=1 -> next cycle out_valid=0, count=0; a new in_valid the following cycle appears after 1 cycle via bypass.
- Random in_valid/out_ready/flush run against a reference queue model -> no reordering, duplication or loss except recorded overflow drops.
